// File: rtl/padmux_pkg.sv
// Shared constants for the pad-mux configuration controller: default bank
// geometry, gap counter width and FSM state encodings.
package padmux_pkg;

    localparam int PADMUX_NUM_PADS = 32;
    localparam int PADMUX_SEL_W    = 2;
    localparam int GAP_CNT_W       = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_DRAIN  = 2'd1;
    localparam state_t ST_SWITCH = 2'd2;

endpackage

// File: rtl/padmux_gap_timer.sv
// Loadable down-counter; done_o is high whenever the count has reached zero.
module padmux_gap_timer
    import padmux_pkg::*;
#(
    parameter int W = GAP_CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/padmux_cfg_ctrl.sv
// Break-before-make pad alternate-function controller behind an OBI-style port.
// Optional lock register at address NUM_PADS when PADMUX_LOCK_EN is defined.
module padmux_cfg_ctrl
    import padmux_pkg::*;
#(
    parameter int                            NUM_PADS   = PADMUX_NUM_PADS,
    parameter int                            SEL_W      = PADMUX_SEL_W,
    parameter int                            GAP_CYCLES = 4,
    parameter logic [NUM_PADS*SEL_W-1:0]     RESET_SEL  = '0,
    parameter int                            ADDR_W     = $clog2(NUM_PADS) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic                      we_i,
    input  logic [ADDR_W-1:0]         addr_i,
    input  logic [SEL_W-1:0]          wdata_i,
    output logic                      r_valid_o,
    output logic [SEL_W-1:0]          r_rdata_o,
    output logic                      r_err_o,
    output logic                      busy_o,
    output logic [NUM_PADS*SEL_W-1:0] pad_sel_o,
    output logic [NUM_PADS-1:0]       pad_oe_mask_o
);

    localparam int                IDX_W      = $clog2(NUM_PADS);
    localparam logic [ADDR_W-1:0] NUM_PADS_A = ADDR_W'(NUM_PADS);

    state_t                             state_q, state_d;
    logic [NUM_PADS-1:0][SEL_W-1:0]     sel_q, sel_d;
    logic [IDX_W-1:0]                   addr_q, addr_d;
    logic [SEL_W-1:0]                   val_q, val_d;
    logic [NUM_PADS-1:0]                mask_q, mask_d;
    logic                               r_valid_q, r_valid_d;
    logic [SEL_W-1:0]                   r_rdata_q, r_rdata_d;
    logic                               r_err_q, r_err_d;
    logic                               gap_load, gap_done, locked;
    logic [IDX_W-1:0]                   idx;

    assign idx = addr_i[IDX_W-1:0];

    padmux_gap_timer #(.W(GAP_CNT_W)) u_gap_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (gap_load),
        .value_i(GAP_CNT_W'(GAP_CYCLES - 1)),
        .done_o (gap_done)
    );

`ifdef PADMUX_LOCK_EN
    logic lock_q, lock_d;

    // Sticky: once set only reset clears it.
    always_comb begin
        lock_d = lock_q;
        if (req_i && gnt_o && we_i && addr_i == NUM_PADS_A && wdata_i[0]) begin
            lock_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        val_d     = val_q;
        r_valid_d = 1'b0;
        r_rdata_d = '0;
        r_err_d   = 1'b0;
        gap_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    r_valid_d = 1'b1;
                    if (addr_i < NUM_PADS_A) begin
                        if (!we_i) begin
                            r_rdata_d = sel_q[idx];
                        end else if (locked) begin
                            r_err_d = 1'b1;
                        end else if (wdata_i != sel_q[idx]) begin
                            state_d  = ST_DRAIN;
                            addr_d   = idx;
                            val_d    = wdata_i;
                            gap_load = 1'b1;
                        end
                    end
`ifdef PADMUX_LOCK_EN
                    else if (addr_i == NUM_PADS_A) begin
                        if (!we_i) begin
                            r_rdata_d = SEL_W'(lock_q);
                        end
                    end
`endif
                    else begin
                        r_err_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Pad has been tristated for the full gap; commit the new select.
                if (gap_done) begin
                    state_d       = ST_SWITCH;
                    sel_d[addr_q] = val_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mask_d = '0;
        if (state_d != ST_IDLE) begin
            mask_d[addr_d] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            sel_q     <= RESET_SEL;
            addr_q    <= '0;
            val_q     <= '0;
            mask_q    <= '0;
            r_valid_q <= 1'b0;
            r_rdata_q <= '0;
            r_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            val_q     <= val_d;
            mask_q    <= mask_d;
            r_valid_q <= r_valid_d;
            r_rdata_q <= r_rdata_d;
            r_err_q   <= r_err_d;
        end
    end

    assign gnt_o         = req_i && (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign r_valid_o     = r_valid_q;
    assign r_rdata_o     = r_rdata_q;
    assign r_err_o       = r_err_q;
    assign pad_sel_o     = sel_q;
    assign pad_oe_mask_o = mask_q;

endmodule

// File: tb/tb_padmux_cfg_ctrl.sv
// Randomized self-checking bench for padmux_cfg_ctrl with a schedule-based
// reference model plus directed literal checks.
module tb_padmux_cfg_ctrl;

    localparam int NP  = 32;
    localparam int SW  = 2;
    localparam int GAP = 4;
    localparam int AW  = 6;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_i = 1'b0;
    logic          we_i = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic [SW-1:0] wdata_i = '0;
    logic          gnt_o, r_valid_o, r_err_o, busy_o;
    logic [SW-1:0] r_rdata_o;
    logic [NP*SW-1:0] pad_sel_o;
    logic [NP-1:0] pad_oe_mask_o;

    int n_chk = 0;
    int n_fail = 0;

    padmux_cfg_ctrl #(.NUM_PADS(NP), .SEL_W(SW), .GAP_CYCLES(GAP)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .r_valid_o(r_valid_o),
        .r_rdata_o(r_rdata_o), .r_err_o(r_err_o), .busy_o(busy_o),
        .pad_sel_o(pad_sel_o), .pad_oe_mask_o(pad_oe_mask_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: pad selects plus the cycle a transition was granted.
    int  msel [NP];
    bit  pend;
    int  ppad, pval, t0;
    int  resp_c;
    int  exp_rd;
    bit  exp_err;

    function automatic logic [63:0] packed_sel();
        logic [63:0] v = '0;
        for (int i = 0; i < NP; i++) v[i*SW +: SW] = SW'(msel[i]);
        return v;
    endfunction

    initial begin
        int  c = 0;
        bit  busy_m;
        int  a;
        logic [63:0] m;
        forever begin
            @(negedge clk);
            c++;
            if (!rst_ni) begin
                for (int i = 0; i < NP; i++) msel[i] = 0;
                pend = 0;
                resp_c = -1;
            end else begin
                if (pend && c == t0 + GAP + 1) msel[ppad] = pval;
                if (pend && c > t0 + GAP + 1) pend = 0;
                busy_m = pend;
                m = '0;
                if (busy_m) m[ppad] = 1'b1;
                chk("m_pad_sel", pad_sel_o, packed_sel());
                chk("m_mask", 64'(pad_oe_mask_o), m);
                chk("m_busy", 64'(busy_o), 64'(busy_m));
                chk("m_rvalid", 64'(r_valid_o), 64'(resp_c == c));
                if (resp_c == c) begin
                    chk("m_rdata", 64'(r_rdata_o), 64'(exp_rd));
                    chk("m_rerr", 64'(r_err_o), 64'(exp_err));
                end
                chk("m_gnt", 64'(gnt_o), 64'(req_i && !busy_m));
                if (req_i && !busy_m) begin
                    a = int'(addr_i);
                    resp_c = c + 1;
                    exp_rd = 0;
                    exp_err = (a >= NP);
                    if (a < NP && !we_i) exp_rd = msel[a];
                    if (a < NP && we_i && int'(wdata_i) != msel[a]) begin
                        pend = 1; ppad = a; pval = int'(wdata_i); t0 = c;
                    end
                end
            end
        end
    end

    // Called just after a posedge; returns just after the posedge following the grant.
    task automatic do_req(input bit we, input int addr, input int wd, output int waits);
        req_i = 1'b1; we_i = we; addr_i = AW'(addr); wdata_i = SW'(wd);
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!gnt_o && waits < 40);
        if (!gnt_o) chk("gnt_timeout", 64'(gnt_o), 64'd1);
        @(posedge clk); #1;
        req_i = 1'b0;
    endtask

    initial begin
        int w;
        int v;
        #1;
        chk("rst_sel", pad_sel_o, 64'd0);
        chk("rst_mask", 64'(pad_oe_mask_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_rvalid", 64'(r_valid_o), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk); #1;

        // Pad 9: 0 -> 2, full break-before-make timeline.
        do_req(1'b1, 9, 2, w);
        @(negedge clk);
        chk("w9_rvalid", 64'(r_valid_o), 64'd1);
        chk("w9_rerr", 64'(r_err_o), 64'd0);
        chk("w9_mask_t1", 64'(pad_oe_mask_o), 64'd1 << 9);
        chk("w9_sel_old", 64'(pad_sel_o[19:18]), 64'd0);
        for (int k = 2; k <= GAP; k++) begin
            @(negedge clk);
            chk("w9_mask_drain", 64'(pad_oe_mask_o), 64'd1 << 9);
            chk("w9_sel_drain", 64'(pad_sel_o[19:18]), 64'd0);
        end
        @(negedge clk);
        chk("w9_sel_switch", pad_sel_o, 64'd2 << 18);
        chk("w9_mask_switch", 64'(pad_oe_mask_o), 64'd1 << 9);
        @(negedge clk);
        chk("w9_mask_idle", 64'(pad_oe_mask_o), 64'd0);
        chk("w9_busy_idle", 64'(busy_o), 64'd0);
        @(posedge clk); #1;

        // Same value: response only.
        do_req(1'b1, 9, 2, w);
        @(negedge clk);
        chk("same_rvalid", 64'(r_valid_o), 64'd1);
        chk("same_busy", 64'(busy_o), 64'd0);
        chk("same_mask", 64'(pad_oe_mask_o), 64'd0);
        @(posedge clk); #1;

        do_req(1'b0, 9, 0, w);
        @(negedge clk);
        chk("rd9_data", 64'(r_rdata_o), 64'd2);
        chk("rd9_err", 64'(r_err_o), 64'd0);
        @(posedge clk); #1;

        do_req(1'b0, 40, 0, w);
        @(negedge clk);
        chk("rd40_err", 64'(r_err_o), 64'd1);
        chk("rd40_data", 64'(r_rdata_o), 64'd0);
        @(posedge clk); #1;

        do_req(1'b1, 40, 3, w);
        @(negedge clk);
        chk("wr40_err", 64'(r_err_o), 64'd1);
        chk("wr40_sel", pad_sel_o, 64'd2 << 18);
        chk("wr40_busy", 64'(busy_o), 64'd0);
        @(posedge clk); #1;

        // Pad 3 request stalls behind pad 9's switch.
        do_req(1'b1, 9, 1, w);
        do_req(1'b1, 3, 1, w);
        chk("stall_cycles", 64'(w), 64'(GAP + 2));
        repeat (GAP + 3) @(posedge clk);
        #1;

        repeat (300) begin
            v = int'($urandom_range(0, 2));
            repeat (v) begin @(posedge clk); #1; end
            do_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 39)),
                   int'($urandom_range(0, 3)), w);
        end
        repeat (GAP + 3) @(posedge clk);
        #1;

        // Reset in the middle of DRAIN.
        v = (msel[5] + 1) % 4;
        do_req(1'b1, 5, v, w);
        @(posedge clk); #2;
        chk("drain_mask", 64'(pad_oe_mask_o), 64'd1 << 5);
        rst_ni = 1'b0;
        #1;
        chk("arst_sel", pad_sel_o, 64'd0);
        chk("arst_mask", 64'(pad_oe_mask_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_rvalid", 64'(r_valid_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk); #1;
        do_req(1'b1, 5, 3, w);
        repeat (GAP + 4) @(posedge clk);
        #1;
        chk("post_rst_sel", pad_sel_o, 64'd3 << 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
